// File: rtl/huff_min2_sched.sv
// huff_min2_sched: linear-scan two-minimum finder for Huffman tree construction.
// It sequences a shared bit-serial comparator through a clear/start/done
// handshake and returns the indices of the two smallest valid frequencies.
// Optional feature: define HUFF_CMP_TIMEOUT_EN to add a comparator watchdog.
module huff_min2_sched #(
    parameter int unsigned NUM_SYMS = 4,
    parameter int unsigned FREQ_W   = 9,
    parameter int unsigned IDX_W    = $clog2(NUM_SYMS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [NUM_SYMS*FREQ_W-1:0] freq_in,
    input  logic [NUM_SYMS-1:0]        valid_in,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [IDX_W-1:0]           min1_idx,
    output logic [IDX_W-1:0]           min2_idx,
    output logic                       cmp_clear,
    output logic                       cmp_start,
    output logic [31:0]                cmp_bits,
    output logic [FREQ_W-1:0]          cmp_a,
    output logic [FREQ_W-1:0]          cmp_b,
    input  logic                       cmp_done,
    input  logic                       cmp_lt,
    input  logic                       cmp_eq,
    input  logic                       cmp_gt
);

    typedef enum logic [2:0] {StIdle, StNext, StClr, StCmp, StDecide, StFin} state_e;

    localparam logic [IDX_W:0] LastI = (IDX_W + 1)'(NUM_SYMS);

    state_e                      state_q, state_d;
    logic [NUM_SYMS*FREQ_W-1:0]  freq_q, freq_d;
    logic [NUM_SYMS-1:0]         valid_q, valid_d;
    logic [IDX_W:0]              i_q, i_d;
    logic [1:0]                  found_q, found_d;
    logic [IDX_W-1:0]            min1_q, min1_d, min2_q, min2_d;
    logic                        tgt_q, tgt_d;     // 1: comparing against min2, 0: against min1
    logic                        first_q, first_d; // first CMP cycle, comparator result is stale
    logic                        lt_q, lt_d;
    logic [FREQ_W-1:0]           a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]            i_idx;
    logic                        lt_eff;
    logic                        to_flag;

    function automatic logic [FREQ_W-1:0] pick(input logic [NUM_SYMS*FREQ_W-1:0] tab,
                                               input logic [IDX_W-1:0] idx);
        pick = tab[int'(idx)*FREQ_W +: FREQ_W];
    endfunction

    assign i_idx  = i_q[IDX_W-1:0];
    // Only an unambiguous less-than displaces; ties keep the lower index.
    assign lt_eff = cmp_lt & ~cmp_eq & ~cmp_gt;

`ifdef HUFF_CMP_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(FREQ_W + 4);
    localparam logic [WD_W-1:0] WdLast = WD_W'(FREQ_W + 3);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    assign to_flag = to_q;
`else
    assign to_flag = 1'b0;
`endif

    // Next-state and datapath updates for the scan FSM.
    always_comb begin
        state_d = state_q;
        freq_d  = freq_q;
        valid_d = valid_q;
        i_d     = i_q;
        found_d = found_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        tgt_d   = tgt_q;
        first_d = first_q;
        lt_d    = lt_q;
        a_d     = a_q;
        b_d     = b_q;
`ifdef HUFF_CMP_TIMEOUT_EN
        wd_d    = wd_q;
        to_d    = to_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    freq_d  = freq_in;
                    valid_d = valid_in;
                    i_d     = '0;
                    found_d = 2'd0;
                    min1_d  = '0;
                    min2_d  = '0;
`ifdef HUFF_CMP_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                    state_d = StNext;
                end
            end
            StNext: begin
                if (i_q == LastI) begin
                    state_d = StFin;
                end else if (!valid_q[i_idx]) begin
                    i_d = i_q + 1'b1;
                end else if (found_q == 2'd0) begin
                    min1_d  = i_idx;
                    found_d = 2'd1;
                    i_d     = i_q + 1'b1;
                end else begin
                    tgt_d   = (found_q == 2'd2);
                    a_d     = pick(freq_q, i_idx);
                    b_d     = (found_q == 2'd2) ? pick(freq_q, min2_q) : pick(freq_q, min1_q);
                    state_d = StClr;
                end
            end
            StClr: begin
                first_d = 1'b1;
`ifdef HUFF_CMP_TIMEOUT_EN
                wd_d    = '0;
`endif
                state_d = StCmp;
            end
            StCmp: begin
                first_d = 1'b0;
                if (!first_q && cmp_done) begin
                    lt_d    = lt_eff;
                    state_d = StDecide;
                end
`ifdef HUFF_CMP_TIMEOUT_EN
                else if (wd_q == WdLast) begin
                    to_d    = 1'b1;
                    state_d = StFin;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            StDecide: begin
                if (tgt_q && !lt_q) begin
                    i_d     = i_q + 1'b1;
                    state_d = StNext;
                end else if (tgt_q) begin
                    // Beat min2; now see whether it also beats min1.
                    tgt_d   = 1'b0;
                    b_d     = pick(freq_q, min1_q);
                    state_d = StClr;
                end else begin
                    if (lt_q) begin
                        min2_d = min1_q;
                        min1_d = i_idx;
                    end else begin
                        min2_d = i_idx;
                    end
                    found_d = 2'd2;
                    i_d     = i_q + 1'b1;
                    state_d = StNext;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            freq_q  <= '0;
            valid_q <= '0;
            i_q     <= '0;
            found_q <= 2'd0;
            min1_q  <= '0;
            min2_q  <= '0;
            tgt_q   <= 1'b0;
            first_q <= 1'b0;
            lt_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
`ifdef HUFF_CMP_TIMEOUT_EN
            wd_q    <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            valid_q <= valid_d;
            i_q     <= i_d;
            found_q <= found_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            tgt_q   <= tgt_d;
            first_q <= first_d;
            lt_q    <= lt_d;
            a_q     <= a_d;
            b_q     <= b_d;
`ifdef HUFF_CMP_TIMEOUT_EN
            wd_q    <= wd_d;
            to_q    <= to_d;
`endif
        end
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        busy      = (state_q == StNext) || (state_q == StClr) ||
                    (state_q == StCmp)  || (state_q == StDecide);
        done      = (state_q == StFin);
        err       = (state_q == StFin) && ((found_q < 2'd2) || to_flag);
        min1_idx  = min1_q;
        min2_idx  = min2_q;
        cmp_clear = (state_q == StClr);
        cmp_start = (state_q == StCmp);
        cmp_bits  = 32'(FREQ_W);
        cmp_a     = a_q;
        cmp_b     = b_q;
    end

endmodule
